// File: rtl/ysyx_24110015_uart_tx.sv
// Byte-FIFO-fed 8N1 UART transmitter: bytes are queued through a valid/ready
// port and serialised LSB first, back-to-back frames with no idle gap.
module ysyx_24110015_uart_tx #(
  parameter int DIV   = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [1:0]               dbg_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DIV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  // Handshake: a byte moves on a rising edge exactly when in_valid and
  // in_ready are both 1; in_ready depends only on registered state.
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ready_q;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic          push;
  logic          pop;
  logic          baud_end;

  assign push     = in_valid & ready_q;
  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (count_q != '0) begin
            // chain straight into the next frame, no idle bit time
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            bit_d   = 3'd0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // tx follows the state one cycle late, so it only ever changes on a clock edge
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= (count_d < FIFO_FULL);
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign in_ready    = ready_q;
  assign tx          = tx_q;
  assign busy        = (state_q != S_IDLE) | (count_q != '0);
  assign fifo_count  = count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ysyx_24110015_uart_tx.sv
// Directed bench for the UART transmitter with DIV=4, DEPTH=8: latency,
// frame shape, back-pressure, back-to-back frames, FIFO wrap and mid-frame reset.
module tb_ysyx_24110015_uart_tx;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       tx;
  logic       busy;
  logic [3:0] fifo_count;
  logic [1:0] dbg_state;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];

  ysyx_24110015_uart_tx #(.DIV(4), .DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .tx          (tx),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .dbg_state_o (dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // START, 8 data bits LSB first, STOP; each bit held 4 cycles
  function automatic logic [39:0] frame_bits(input logic [7:0] b);
    logic [39:0] f;
    for (int i = 0; i < 40; i++) begin
      if (i / 4 == 0)      f[i] = 1'b0;
      else if (i / 4 == 9) f[i] = 1'b1;
      else                 f[i] = b[i / 4 - 1];
    end
    return f;
  endfunction

  // called on the first cycle of a frame; leaves on its last cycle
  task automatic frame_check(input logic [7:0] b, input string tag);
    logic [39:0] obs;
    for (int i = 0; i < 40; i++) begin
      obs[i] = tx;
      if (i < 39) tick();
    end
    check(tag, obs, frame_bits(b));
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain_scoreboard(input string tag);
    logic [7:0] b;
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      frame_check(b, tag);
      tick();
    end
  endtask

  initial begin
    logic stay_ok;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // reset state
    ticks(3);
    check("rst_tx", tx, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b1;
    tick();
    check("release_in_ready", in_ready, 1);

    // single byte 0x55: latency and frame shape
    push_byte(8'h55);
    check("lat_count", fifo_count, 1);
    check("lat_busy", busy, 1);
    tick();
    check("lat_tx_n1", tx, 1);
    tick();
    check("lat_tx_n2", tx, 0);
    frame_check(8'h55, "frame_55");
    tick();
    check("idle_tx_55", tx, 1);
    check("idle_busy_55", busy, 0);

    // two bytes back to back
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_data  = 8'h3C;
    tick();
    in_valid = 1'b0;
    tick();
    check("b2b_start", tx, 0);
    frame_check(8'hA5, "frame_a5");
    tick();
    frame_check(8'h3C, "frame_3c");
    tick();
    check("idle_tx_b2b", tx, 1);
    check("idle_busy_b2b", busy, 0);

    // in_valid held, data changing every cycle: fill, back-pressure, re-accept
    stay_ok  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 43; i++) begin
      in_data = 8'(16 + i);
      tick();
      if (i == 9) begin
        check("full_count", fifo_count, 8);
        check("full_ready", in_ready, 0);
      end
      if (i >= 10 && i <= 40) begin
        if (in_ready !== 1'b0 || fifo_count !== 4'd8) stay_ok = 1'b0;
      end
      if (i == 41) begin
        check("reready_ready", in_ready, 1);
        check("reready_count", fifo_count, 7);
      end
    end
    in_valid = 1'b0;
    check("ready_held_low", stay_ok, 1);
    check("refill_count", fifo_count, 8);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(17 + i));
    exp_q.push_back(8'h3A);
    drain_scoreboard("frame_fill");
    check("fill_idle_tx", tx, 1);
    check("fill_idle_busy", busy, 0);
    check("fill_idle_count", fifo_count, 0);

    // push and pop on the same edge with 3 bytes held
    in_valid = 1'b1;
    in_data  = 8'h81; tick();
    in_data  = 8'h42; tick();
    in_data  = 8'hC3; tick();
    in_data  = 8'h24; tick();
    in_valid = 1'b0;
    ticks(37);
    check("pp_count_before", fifo_count, 3);
    push_byte(8'hE7);
    check("pp_count_after", fifo_count, 3);
    tick();
    exp_q.push_back(8'h42);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h24);
    exp_q.push_back(8'hE7);
    drain_scoreboard("frame_pp");
    check("pp_idle_busy", busy, 0);

    // reset during DATA bit 3 with 3 bytes queued
    in_valid = 1'b1;
    in_data  = 8'hF7; tick();
    in_data  = 8'h11; tick();
    in_data  = 8'h22; tick();
    in_data  = 8'h33; tick();
    in_valid = 1'b0;
    ticks(15);
    check("mid_bit3_tx", tx, 0);
    check("mid_state", dbg_state, 2);
    check("mid_count", fifo_count, 3);
    rst = 1'b0;
    tick();
    check("abort_tx", tx, 1);
    check("abort_count", fifo_count, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", in_ready, 0);
    rst = 1'b1;
    tick();
    check("abort_release_ready", in_ready, 1);
    stay_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) stay_ok = 1'b0;
    end
    check("abort_quiet", stay_ok, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
